drop_sequencer: RTL and testbench

- Sequences sand drops into the sandpile grid engine.
- Takes candidate coordinates each cycle from the game controller (centre or alternating-RNG x/y) and paces drops with a programmable interval.
- Rejects out-of-range coordinates, with bounded retries.
- Issues each accepted drop over a valid/ready handshake, then holds off until the grid reports it has stabilised.

---
 rtl/drop_sequencer.sv | 144 ++++++++++++++
 tb/tb_drop_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/drop_sequencer.sv
// Paces sand drops into the sandpile grid: waits an interval, samples candidate
// coordinates with bounded retries, issues over valid/ready, then waits for the grid to settle.
module drop_sequencer #(
  parameter int COORD_W   = 9,
  parameter int CNT_W     = 16,
  parameter int MAX_RETRY = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               step,
  input  logic [CNT_W-1:0]   interval,
  input  logic [COORD_W-1:0] resolution,
  input  logic [COORD_W-1:0] cand_x,
  input  logic [COORD_W-1:0] cand_y,
  output logic               drop_valid,
  input  logic               drop_ready,
  output logic [COORD_W-1:0] drop_x,
  output logic [COORD_W-1:0] drop_y,
  input  logic               grid_busy,
  output logic               busy,
  output logic [CNT_W-1:0]   drop_count,
  output logic               retry_fail,
  output logic [2:0]         state_dbg
);

  // Handshake: drop_valid rises in ISSUE and stays high with drop_x/drop_y frozen
  // until a clock edge sees drop_valid && drop_ready; drop_ready alone means nothing.

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    SAMPLE = 3'd2,
    ISSUE  = 3'd3,
    SETTLE = 3'd4
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   timer, timer_next;
  logic [RW-1:0]      retry_cnt, retry_next;
  logic               settle_first, first_next;
  logic [COORD_W-1:0] x_next, y_next;
  logic [CNT_W-1:0]   count_next;
  logic               fail_next;
  logic               cand_ok;

  assign cand_ok    = (cand_x < resolution) && (cand_y < resolution);
  assign drop_valid = (state == ISSUE);
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      retry_cnt    <= '0;
      settle_first <= 1'b0;
      drop_x       <= '0;
      drop_y       <= '0;
      drop_count   <= '0;
      retry_fail   <= 1'b0;
    end else begin
      state        <= state_next;
      timer        <= timer_next;
      retry_cnt    <= retry_next;
      settle_first <= first_next;
      drop_x       <= x_next;
      drop_y       <= y_next;
      drop_count   <= count_next;
      retry_fail   <= fail_next;
    end
  end

  always_comb begin
    state_next = state;
    timer_next = timer;
    retry_next = retry_cnt;
    first_next = settle_first;
    x_next     = drop_x;
    y_next     = drop_y;
    count_next = drop_count;
    fail_next  = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          timer_next = interval;
          state_next = WAIT;
        end else if (step) begin
          state_next = SAMPLE;
        end
      end
      WAIT: begin
        if (!enable)             state_next = IDLE;
        else if (timer == '0)    state_next = SAMPLE;
        else                     timer_next = timer - CNT_W'(1);
      end
      SAMPLE: begin
        x_next = cand_x;
        y_next = cand_y;
        if (cand_ok) begin
          retry_next = '0;
          state_next = ISSUE;
        end else if (retry_cnt == RETRY_LAST) begin
          // Give up on this drop; the pacing timer restarts as if it had been issued.
          fail_next  = 1'b1;
          retry_next = '0;
          if (enable) begin
            timer_next = interval;
            state_next = WAIT;
          end else begin
            state_next = IDLE;
          end
        end else begin
          retry_next = retry_cnt + RW'(1);
        end
      end
      ISSUE: begin
        if (drop_ready) begin
          if (drop_count != '1) count_next = drop_count + CNT_W'(1);
          first_next = 1'b1;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        // The grid may take a cycle to raise grid_busy after accepting the drop.
        if (settle_first) begin
          first_next = 1'b0;
        end else if (!grid_busy) begin
          if (enable) begin
            timer_next = interval;
            state_next = WAIT;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_drop_sequencer.sv
// Self-checking bench for drop_sequencer: expected drops are queued as candidates
// are driven and checked against each handshake; drop_count is tracked by a model.
module tb_drop_sequencer;

  localparam int COORD_W = 9;
  localparam int CNT_W   = 16;
  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_SAMPLE = 3'd2,
                         S_ISSUE = 3'd3, S_SETTLE = 3'd4;

  logic               clk = 1'b0;
  logic               rst, enable, step, drop_ready, grid_busy;
  logic [CNT_W-1:0]   interval;
  logic [COORD_W-1:0] resolution, cand_x, cand_y;
  logic               drop_valid, busy, retry_fail;
  logic [COORD_W-1:0] drop_x, drop_y;
  logic [CNT_W-1:0]   drop_count;
  logic [2:0]         state_dbg;

  drop_sequencer #(.COORD_W(COORD_W), .CNT_W(CNT_W), .MAX_RETRY(7)) dut (
    .clk(clk), .rst(rst), .enable(enable), .step(step), .interval(interval),
    .resolution(resolution), .cand_x(cand_x), .cand_y(cand_y),
    .drop_valid(drop_valid), .drop_ready(drop_ready), .drop_x(drop_x), .drop_y(drop_y),
    .grid_busy(grid_busy), .busy(busy), .drop_count(drop_count),
    .retry_fail(retry_fail), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int fail_pulses = 0;
  int sample_cycles = 0;
  int hs_cyc_q[$];
  logic [2*COORD_W-1:0] exp_q[$];
  logic [CNT_W-1:0] model_count = '0;
  logic mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard / monitor
  always @(negedge clk) begin
    if (mon_en) begin
      check("drop_count", drop_count, model_count);
      if (retry_fail) fail_pulses++;
      if (state_dbg == S_SAMPLE) sample_cycles++;
      if (rst) begin
        model_count = '0;
        exp_q.delete();
      end else if (drop_valid && drop_ready) begin
        hs_cnt++;
        hs_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) check("unexpected_drop", 1, 0);
        else check("drop_xy", {drop_x, drop_y}, exp_q.pop_front());
        if (model_count != '1) model_count = model_count + 1'b1;
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick(1);
    step = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int bound, input string tag);
    int n = 0;
    @(negedge clk);
    while (state_dbg != s && n < bound) begin @(negedge clk); n++; end
    if (state_dbg != s) check({tag, "_timeout"}, {29'd0, state_dbg}, {29'd0, s});
  endtask

  task automatic wait_hs(input int n, input int bound, input string tag);
    int target = hs_cnt + n;
    int k = 0;
    while (hs_cnt < target && k < bound) begin @(negedge clk); k++; end
    if (hs_cnt < target) check({tag, "_hs_timeout"}, hs_cnt, target);
  endtask

  logic [COORD_W-1:0] hx, hy;
  int c0, base;

  initial begin
    rst = 1'b1; enable = 1'b1; step = 1'b0; drop_ready = 1'b1; grid_busy = 1'b0;
    interval = 16'd3; resolution = 9'd32; cand_x = 9'd16; cand_y = 9'd16;

    // reset / idle
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_valid", drop_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, S_IDLE);
    check("rst_xy", {drop_x, drop_y}, 0);
    check("rst_retry_fail", retry_fail, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    c0 = cyc;

    // auto pacing, interval=3: first valid interval+3 edges after release, then every 8
    repeat (3) exp_q.push_back({9'd16, 9'd16});
    wait_state(S_ISSUE, 40, "first_valid");
    check("first_valid_latency", cyc - c0, 6);
    wait_hs(3, 60, "pacing");
    check("pace_gap1", hs_cyc_q[1] - hs_cyc_q[0], 8);
    check("pace_gap2", hs_cyc_q[2] - hs_cyc_q[1], 8);
    check("pace_count3", model_count, 3);

    // backpressure: valid/x/y stable for 10 cycles while ready is low
    tick(1);
    drop_ready = 1'b0;
    exp_q.push_back({9'd16, 9'd16});
    wait_state(S_ISSUE, 20, "bp_issue");
    hx = drop_x; hy = drop_y;
    cand_x = 9'd20; cand_y = 9'd21; interval = 16'd0;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", drop_valid, 1);
      check("bp_xy", {drop_x, drop_y}, {hx, hy});
      @(negedge clk);
    end
    base = hs_cnt;
    @(posedge clk); #1;
    drop_ready = 1'b1; grid_busy = 1'b1;
    exp_q.push_back({9'd20, 9'd21});
    tick(1);
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      check("busy_hold_settle", state_dbg, S_SETTLE);
      tick(1);
    end
    check("bp_one_hs", hs_cnt - base, 1);
    grid_busy = 1'b0;
    @(negedge clk);
    check("busy_fall_settle", state_dbg, S_SETTLE);
    @(negedge clk);
    check("after_busy_wait", state_dbg, S_WAIT);
    @(negedge clk);
    check("after_busy_sample", state_dbg, S_SAMPLE);
    wait_hs(1, 10, "post_busy");
    @(posedge clk); #1;
    enable = 1'b0;
    wait_state(S_IDLE, 20, "to_idle");

    // range reject with recovery: x stream 12, 40, 5 with y=3
    resolution = 9'd10; cand_x = 9'd12; cand_y = 9'd3;
    base = fail_pulses;
    c0 = sample_cycles;
    @(posedge clk); #1;
    exp_q.push_back({9'd5, 9'd3});
    pulse_step();
    tick(1);
    cand_x = 9'd40;
    tick(1);
    cand_x = 9'd5;
    wait_hs(1, 10, "reject");
    check("reject_samples", sample_cycles - c0, 3);
    check("reject_no_fail", fail_pulses - base, 0);
    wait_state(S_IDLE, 10, "step_idle");

    // resolution=0: skip after 7 samples, retry_fail pulses once, count unchanged
    resolution = 9'd0;
    base = fail_pulses;
    c0 = sample_cycles;
    @(posedge clk); #1;
    pulse_step();
    tick(12);
    @(negedge clk);
    check("res0_fail_pulse", fail_pulses - base, 1);
    check("res0_samples", sample_cycles - c0, 7);
    check("res0_state", state_dbg, S_IDLE);

    // step ignored in ISSUE/SETTLE; single step drop returns to IDLE
    resolution = 9'd32; cand_x = 9'd7; cand_y = 9'd9; drop_ready = 1'b0;
    base = hs_cnt;
    @(posedge clk); #1;
    exp_q.push_back({9'd7, 9'd9});
    pulse_step();
    wait_state(S_ISSUE, 10, "step_issue");
    @(posedge clk); #1;
    pulse_step();
    drop_ready = 1'b1;
    tick(1);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(8);
    @(negedge clk);
    check("step_one_drop", hs_cnt - base, 1);
    check("step_end_idle", state_dbg, S_IDLE);

    // enable falling in WAIT returns to IDLE next cycle
    interval = 16'd20;
    @(posedge clk); #1;
    enable = 1'b1;
    tick(3);
    @(negedge clk);
    check("wait_state", state_dbg, S_WAIT);
    @(posedge clk); #1;
    enable = 1'b0;
    @(negedge clk);
    check("wait_to_idle", state_dbg, S_WAIT);
    @(negedge clk);
    check("wait_abort_idle", state_dbg, S_IDLE);

    // saturation: preload near the top, two more drops stick at all-ones
    @(posedge clk); #1;
    force dut.drop_count = 16'hFFFE;
    model_count = 16'hFFFE;
    tick(1);
    release dut.drop_count;
    cand_x = $urandom_range(0, 31); cand_y = $urandom_range(0, 31);
    exp_q.push_back({cand_x, cand_y});
    pulse_step();
    wait_hs(1, 10, "sat1");
    wait_state(S_IDLE, 10, "sat1_idle");
    @(posedge clk); #1;
    cand_x = $urandom_range(0, 31); cand_y = $urandom_range(0, 31);
    exp_q.push_back({cand_x, cand_y});
    pulse_step();
    wait_hs(1, 10, "sat2");
    @(negedge clk);
    check("sat_value", drop_count, 16'hFFFF);

    // reset while drop_valid is high
    wait_state(S_IDLE, 10, "pre_rst_idle");
    drop_ready = 1'b0;
    @(posedge clk); #1;
    pulse_step();
    wait_state(S_ISSUE, 10, "rst_mid_issue");
    @(posedge clk); #1;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", drop_valid, 0);
    check("rst_mid_count", drop_count, 0);
    check("rst_mid_state", state_dbg, S_IDLE);
    tick(3);
    @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
